// File: rtl/soi_monitor_pkg.sv
// Shared constants and record-layout helpers for the SOI change monitor.
// A record is {ts, soi}, with the timestamp in the upper bits.
package soi_monitor_pkg;

    localparam int SOI_W_DEF = 8;
    localparam int DEPTH_DEF = 16;
    localparam int TS_W_DEF  = 16;

    localparam int              DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    function automatic int ts_lsb(input int soi_w);
        return soi_w;
    endfunction

    function automatic int rec_width(input int ts_w, input int soi_w);
        return ts_w + soi_w;
    endfunction

    localparam int TS_LSB = ts_lsb(SOI_W_DEF);

endpackage

// File: rtl/soi_monitor_if.sv
// Host-facing read port of the SOI monitor: record stream plus status.
// The monitor drives it through the master modport, the reader through slave.
interface soi_monitor_if
    import soi_monitor_pkg::*;
#(
    parameter int SOI_W = SOI_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    localparam int REC_W = rec_width(TS_W, SOI_W);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              rd_valid;
    logic [REC_W-1:0]  rd_data;
    logic              rd_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output rd_valid,
        output rd_data,
        output count,
        output overflow,
        output drop_cnt,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  count,
        input  overflow,
        input  drop_cnt,
        output rd_ready
    );

endinterface

// File: rtl/soi_fifo.sv
// Synchronous FIFO with a separate occupancy counter; a push into a full
// FIFO is still accepted when a pop happens on the same edge.
module soi_fifo
    import soi_monitor_pkg::*;
#(
    parameter int WIDTH = rec_width(TS_W_DEF, SOI_W_DEF),
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;
    assign count   = cnt;

    // Empty FIFO presents zero so stale storage never leaks onto the bus.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/soi_monitor.sv
// Samples the SOI probe vector every clock, logs a timestamped record on each
// change (plus a baseline on every enable), and buffers records for the host.
module soi_monitor
    import soi_monitor_pkg::*;
#(
    parameter int SOI_W = SOI_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SOI_W-1:0] soi,
    input  logic             enable,
    input  logic             clear,
    soi_monitor_if.master    rd
);

    localparam int REC_W   = rec_width(TS_W, SOI_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int REC_LSB = ts_lsb(SOI_W);

    logic [TS_W-1:0]   ts;
    logic [SOI_W-1:0]  soi_prev;
    logic              armed;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    logic              push;
    logic              pop;
    logic              drop;
    logic [REC_W-1:0]  rec;
    logic [REC_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_W'(1);
    endfunction

    // Capture stage: baseline on the first enabled edge, then changes only.
    assign push = enable && !clear && (!armed || (soi != soi_prev));
    assign pop  = rd.rd_valid && rd.rd_ready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        rec = '0;
        rec[REC_W-1:REC_LSB] = ts;
        rec[REC_LSB-1:0]     = soi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts       <= '0;
            soi_prev <= '0;
            armed    <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            soi_prev <= soi;
            if (clear) begin
                ts       <= '0;
                armed    <= 1'b0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                ts    <= ts + TS_W'(1);
                armed <= enable;
                if (drop) begin
                    overflow <= 1'b1;
                    drop_cnt <= sat_inc(drop_cnt);
                end
            end
        end
    end

    // Buffer stage: records wait here until the host reads them.
    soi_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (rec),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rd.rd_valid = !fifo_empty;
    assign rd.rd_data  = fifo_dout;
    assign rd.count    = fifo_count;
    assign rd.overflow = overflow;
    assign rd.drop_cnt = drop_cnt;

endmodule

// File: tb/tb_soi_monitor.sv
// Scoreboard bench for soi_monitor: directed stimulus pushes expected records,
// a forked monitor pops and compares each record the DUT hands over.
module tb_soi_monitor;

    localparam int SOI_W = 8;
    localparam int TS_W  = 16;
    localparam int DEPTH = 16;
    localparam int REC_W = TS_W + SOI_W;

    logic             clk;
    logic             reset;
    logic [SOI_W-1:0] soi;
    logic             enable;
    logic             clear;

    logic [TS_W-1:0]  edge_ts;
    logic [REC_W-1:0] exp_q[$];
    int               checks;
    int               errors;

    soi_monitor_if #(.SOI_W(SOI_W), .TS_W(TS_W), .DEPTH(DEPTH)) bus ();

    soi_monitor #(
        .SOI_W (SOI_W),
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .soi    (soi),
        .enable (enable),
        .clear  (clear),
        .rd     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; the bench timestamp model follows the DUT's free-running ts.
    task automatic tick();
        logic zero;
        zero = reset || clear;
        @(posedge clk);
        #1;
        if (zero) edge_ts = '0;
        else      edge_ts = edge_ts + 16'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_rec();
        exp_q.push_back({edge_ts, soi});
    endtask

    task automatic chk_q_empty(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic monitor();
        logic [REC_W-1:0] r;
        forever begin
            @(negedge clk);
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got 0x%0h, expected no record", bus.rd_data);
                end else begin
                    r = exp_q.pop_front();
                    chk("record", 32'(bus.rd_data), 32'(r));
                end
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        edge_ts      = '0;
        reset        = 1'b1;
        soi          = 8'h00;
        enable       = 1'b0;
        clear        = 1'b0;
        bus.rd_ready = 1'b0;

        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: got timeout, expected finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        edge_ts = '0;

        // Reset state.
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_rd_data",  32'(bus.rd_data),  32'd0);
        chk("reset_count",    32'(bus.count),    32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        // Baseline: one record {ts=1, 0x00}, then nothing while soi holds.
        tick();
        chk("pre_enable_count", 32'(bus.count), 32'd0);
        enable = 1'b1;
        exp_q.push_back({16'd1, 8'h00});
        tick();
        chk("baseline_count", 32'(bus.count), 32'd1);
        chk("baseline_valid", 32'(bus.rd_valid), 32'd1);
        ticks(4);
        chk("baseline_hold_count", 32'(bus.count), 32'd1);
        bus.rd_ready = 1'b1;
        tick();
        chk("baseline_drained", 32'(bus.count), 32'd0);
        chk_q_empty("baseline_q");

        // Change sequence with the reader always ready.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        soi = 8'h00;
        expect_rec();
        tick();
        soi = 8'h05;
        expect_rec();
        tick();
        ticks(3);
        soi = 8'hA0;
        expect_rec();
        tick();
        ticks(2);
        chk("changes_count", 32'(bus.count), 32'd0);
        chk_q_empty("changes_q");

        // Overflow: 20 changes into a 16-deep FIFO.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            soi = ~soi;
            if (i < 16) expect_rec();
            tick();
        end
        chk("ovf_count",    32'(bus.count),    32'd16);
        chk("ovf_overflow", 32'(bus.overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd4);
        bus.rd_ready = 1'b1;
        ticks(16);
        chk("ovf_drained", 32'(bus.count), 32'd0);
        chk("ovf_sticky",  32'(bus.overflow), 32'd1);
        chk_q_empty("ovf_q");

        // Clear with 7 entries, then baseline with ts restarted at 0.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            soi = ~soi;
            expect_rec();
            tick();
        end
        chk("pre_clear_count", 32'(bus.count), 32'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        chk("clear_count",    32'(bus.count),    32'd0);
        chk("clear_valid",    32'(bus.rd_valid), 32'd0);
        chk("clear_overflow", 32'(bus.overflow), 32'd0);
        chk("clear_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        exp_q.push_back({16'd0, soi});
        tick();
        chk("post_clear_count", 32'(bus.count), 32'd1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        expect_rec();
        tick();
        chk("reenable_count", 32'(bus.count), 32'd2);

        // Full FIFO with push and pop on the same edge.
        for (int i = 0; i < 14; i++) begin
            soi = ~soi;
            expect_rec();
            tick();
        end
        chk("full_count",    32'(bus.count),    32'd16);
        chk("full_overflow", 32'(bus.overflow), 32'd0);
        bus.rd_ready = 1'b1;
        soi = ~soi;
        expect_rec();
        tick();
        bus.rd_ready = 1'b0;
        chk("pushpop_count",    32'(bus.count),    32'd16);
        chk("pushpop_overflow", 32'(bus.overflow), 32'd0);
        chk("pushpop_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        bus.rd_ready = 1'b1;
        ticks(16);
        chk("pushpop_drained", 32'(bus.count), 32'd0);
        chk_q_empty("pushpop_q");

        // Asynchronous reset mid-cycle with 9 entries held.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            soi = ~soi;
            expect_rec();
            tick();
        end
        chk("pre_reset_count", 32'(bus.count),    32'd9);
        chk("pre_reset_valid", 32'(bus.rd_valid), 32'd1);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        #1;
        chk("areset_valid",    32'(bus.rd_valid), 32'd0);
        chk("areset_data",     32'(bus.rd_data),  32'd0);
        chk("areset_count",    32'(bus.count),    32'd0);
        chk("areset_overflow", 32'(bus.overflow), 32'd0);
        chk("areset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        tick();
        reset = 1'b0;
        bus.rd_ready = 1'b1;
        ticks(3);
        chk("post_reset_valid", 32'(bus.rd_valid), 32'd0);
        chk("post_reset_count", 32'(bus.count),    32'd0);
        enable = 1'b1;
        expect_rec();
        tick();
        ticks(2);
        chk_q_empty("post_reset_q");

        // Drop counter saturates at 255.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 16 + 260; i++) begin
            soi = ~soi;
            if (i < 16) expect_rec();
            tick();
        end
        chk("sat_count",    32'(bus.count),    32'd16);
        chk("sat_overflow", 32'(bus.overflow), 32'd1);
        chk("sat_drop_cnt", 32'(bus.drop_cnt), 32'd255);
        bus.rd_ready = 1'b1;
        ticks(17);
        chk("sat_drained", 32'(bus.count), 32'd0);
        chk_q_empty("sat_q");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
